// File: rtl/ab_pair_serializer_pkg.sv
// Shared types and helpers for the a/b pair serializer.
package ab_pair_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int GAP_W = 4;

   function automatic int calc_pairs(input int width);
      return width / 2;
   endfunction

endpackage

// File: rtl/ab_pair_shifter.sv
// Load/shift register that advances one 2-bit pair per shift, in MSB- or LSB-first order.
module ab_pair_shifter #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic [1:0]       pair,
   output logic [1:0]       load_pair
);

   logic [WIDTH-1:0] sr_p0;

   // a is always the higher bit index of the pair, whichever end leads
   function automatic logic [1:0] head(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return w[WIDTH-1 -: 2];
      else           return w[1:0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return w << 2;
      else           return w >> 2;
   endfunction

   // The loaded word's first pair leaves via load_pair, so store it already advanced
   always_ff @(posedge clk) begin
      if (load)       sr_p0 <= advance(data);
      else if (shift) sr_p0 <= advance(sr_p0);
   end

   assign pair      = head(sr_p0);
   assign load_pair = head(data);

endmodule

// File: rtl/ab_pair_serializer.sv
// Serializes a WIDTH-bit word into registered a/b pairs behind a valid/ready handshake.
// Optional even-parity trailer pair: define AB_PAIR_SERIALIZER_PARITY_EN.
module ab_pair_serializer
   import ab_pair_serializer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_a,
   output logic             o_b,
   output logic             o_strobe,
   output logic             o_first,
   output logic             o_last,
   output logic             o_busy
);

   localparam int PAIRS = calc_pairs(WIDTH);
`ifdef AB_PAIR_SERIALIZER_PARITY_EN
   localparam int TOTAL = PAIRS + 1;
`else
   localparam int TOTAL = PAIRS;
`endif
   localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
   localparam logic [GAP_W-1:0] GAP_END  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   if ((WIDTH % 2) != 0 || WIDTH < 2 || GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_check
      $fatal(1, "ab_pair_serializer: WIDTH must be even and >= 2, GAP_CYCLES must be 0..15");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             load, shift;
   logic [1:0]       pair, load_pair;
   logic             a_d, b_d, strobe_d, first_d, last_d;

   ab_pair_shifter #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clk       (i_clk),
      .load      (load),
      .shift     (shift),
      .data      (i_data),
      .pair      (pair),
      .load_pair (load_pair)
   );

`ifdef AB_PAIR_SERIALIZER_PARITY_EN
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAIRS - 1);
   logic parity_q;

   always_ff @(posedge i_clk) begin
      if (load) parity_q <= ^i_data;
   end
`endif

   assign o_ready = (state_q == IDLE);
   assign o_busy  = (state_q != IDLE);

   // Next-state logic; output values are computed one cycle ahead and registered
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      load     = 1'b0;
      shift    = 1'b0;
      strobe_d = 1'b0;
      a_d      = 1'b0;
      b_d      = 1'b0;
      first_d  = 1'b0;
      last_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               load       = 1'b1;
               state_d    = SHIFT;
               cnt_d      = '0;
               strobe_d   = 1'b1;
               {a_d, b_d} = load_pair;
               first_d    = 1'b1;
               last_d     = (LAST_IDX == '0);
            end
         end
         SHIFT: begin
            if (cnt_q == LAST_IDX) begin
               gap_d   = '0;
               state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
               cnt_d    = cnt_q + 1'b1;
               strobe_d = 1'b1;
               last_d   = (cnt_d == LAST_IDX);
`ifdef AB_PAIR_SERIALIZER_PARITY_EN
               if (cnt_q == DATA_LAST) begin
                  {a_d, b_d} = {parity_q, ~parity_q};
               end else begin
                  {a_d, b_d} = pair;
                  shift      = 1'b1;
               end
`else
               {a_d, b_d} = pair;
               shift      = 1'b1;
`endif
            end
         end
         GAP: begin
            if (gap_q == GAP_END) state_d = IDLE;
            else                  gap_d   = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         gap_q    <= '0;
         o_a      <= 1'b0;
         o_b      <= 1'b0;
         o_strobe <= 1'b0;
         o_first  <= 1'b0;
         o_last   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         o_a      <= a_d;
         o_b      <= b_d;
         o_strobe <= strobe_d;
         o_first  <= first_d;
         o_last   <= last_d;
      end
   end

endmodule

// File: tb/tb_ab_pair_serializer.sv
// Scoreboard bench: an MSB-first/no-gap instance and an LSB-first/2-gap instance side by side.
module tb_ab_pair_serializer;

`ifdef AB_PAIR_SERIALIZER_PARITY_EN
   localparam int TOTAL = 5;
`else
   localparam int TOTAL = 4;
`endif

   typedef struct {
      logic [3:0] v;
      int         cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      valid;
   logic [1:0][7:0] data;
   logic [1:0]      ready, a, b, strobe, first, last, busy;

   exp_t            q0[$];
   exp_t            q1[$];
   int              n_cmp = 0;
   int              n_err = 0;
   int              cyc = 0;
   logic [1:0]      hs_pend;
   logic [1:0][7:0] hs_data;
   logic [1:0]      vheld;
   int              prev_hs[2];
   int              busy_end[2];

   always #5 clk = ~clk;

   ab_pair_serializer #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) u_msb (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .o_ready(ready[0]), .i_data(data[0]),
      .o_a(a[0]), .o_b(b[0]), .o_strobe(strobe[0]), .o_first(first[0]), .o_last(last[0]),
      .o_busy(busy[0])
   );

   ab_pair_serializer #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) u_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .o_ready(ready[1]), .i_data(data[1]),
      .o_a(a[1]), .o_b(b[1]), .o_strobe(strobe[1]), .o_first(first[1]), .o_last(last[1]),
      .o_busy(busy[1])
   );

   function automatic int gap_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   // Pair k of word d; k == 4 is the parity trailer {even parity, its inverse}
   function automatic logic [1:0] pair_of(input logic [7:0] d, input int k, input bit msb);
      logic [7:0] s;
      if (k == 4) return {^d, ~(^d)};
      s = msb ? (d >> (6 - 2 * k)) : (d >> (2 * k));
      return s[1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int i, input exp_t e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic monitor();
      for (int i = 0; i < 2; i++) begin
         string nm;
         exp_t  e;
         bit    due;
         nm  = (i == 0) ? "msb" : "lsb";
         due = 1'b0;
         e.v = '0;
         e.cyc = 0;
         if (!rst_n) begin
            chk({nm, ".rst_outs"},
                {ready[i], strobe[i], busy[i], a[i], b[i], first[i], last[i]}, 7'b1000000);
            if (i == 0) q0.delete();
            else        q1.delete();
            busy_end[i] = cyc - 1;
            prev_hs[i]  = -1;
            vheld[i]    = 1'b0;
         end else begin
            if (hs_pend[i]) begin
               if (vheld[i] && prev_hs[i] >= 0)
                  chk({nm, ".period"}, cyc - prev_hs[i], TOTAL + gap_of(i) + 1);
               prev_hs[i] = cyc;
               vheld[i]   = 1'b1;
               for (int k = 0; k < TOTAL; k++) begin
                  e.v   = {pair_of(hs_data[i], k, i == 0), k == 0, k == TOTAL - 1};
                  e.cyc = cyc + k;
                  push(i, e);
               end
               busy_end[i] = cyc + TOTAL + gap_of(i) - 1;
            end
            chk({nm, ".ready"}, ready[i], cyc > busy_end[i]);
            chk({nm, ".busy"},  busy[i],  cyc <= busy_end[i]);
            if (i == 0) begin
               if (q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); due = 1'b1; end
            end else begin
               if (q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); due = 1'b1; end
            end
            chk({nm, ".strobe"}, strobe[i], due);
            if (due) chk({nm, ".pair_ab_first_last"}, {a[i], b[i], first[i], last[i]}, e.v);
            else     chk({nm, ".idle_outs"}, {a[i], b[i], first[i], last[i]}, 4'b0000);
         end
      end
   endtask

   // One clock: note pending handshakes, then check outputs at the falling edge
   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         hs_pend[i] = valid[i] && ready[i] && rst_n;
         hs_data[i] = data[i];
         if (!valid[i]) vheld[i] = 1'b0;
      end
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   task automatic send(input logic [1:0] m, input logic [7:0] d);
      int guard;
      guard = 0;
      while ((ready & m) != m && guard < 40) begin
         tick();
         guard++;
      end
      chk("send_wait_ready", guard < 40, 1);
      for (int i = 0; i < 2; i++) if (m[i]) begin valid[i] = 1'b1; data[i] = d; end
      tick();
      for (int i = 0; i < 2; i++) if (m[i]) begin valid[i] = 1'b0; data[i] = ~d; end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0 || ready != 2'b11) && guard < 60) begin
         tick();
         guard++;
      end
      chk("drain_timeout", guard < 60, 1);
      tick();
   endtask

   // Valid held high across three words; data scrambled whenever the DUT is not ready
   task automatic stream(input logic [2:0][7:0] w);
      int idx[2];
      int guard;
      idx   = '{0, 0};
      guard = 0;
      valid = 2'b11;
      data[0] = w[0];
      data[1] = w[0];
      while ((idx[0] < 3 || idx[1] < 3) && guard < 100) begin
         tick();
         guard++;
         for (int i = 0; i < 2; i++) begin
            if (hs_pend[i]) idx[i]++;
            if (idx[i] >= 3)   valid[i] = 1'b0;
            else if (ready[i]) data[i]  = w[idx[i]];
            else               data[i]  = 8'($urandom);
         end
      end
      chk("stream_timeout", guard < 100, 1);
      valid = 2'b00;
   endtask

   initial begin
      rst_n    = 1'b0;
      valid    = 2'b11;
      data[0]  = 8'hA5;
      data[1]  = 8'hA5;
      hs_pend  = '0;
      hs_data  = '0;
      vheld    = '0;
      prev_hs  = '{-1, -1};
      busy_end = '{-1, -1};

      repeat (3) tick();
      rst_n = 1'b1;
      valid = 2'b00;
      tick();
      tick();

      send(2'b11, 8'hB4);
      wait_idle();

      stream({8'h5A, 8'hFF, 8'h00});
      wait_idle();

      send(2'b11, 8'hC3);
      tick();
      @(posedge clk);
      #1 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send(2'b11, 8'h3C);
      wait_idle();

      send(2'b11, 8'h07);
      wait_idle();
      send(2'b11, 8'h03);
      wait_idle();

      for (int r = 0; r < 4; r++) send(2'b11, 8'($urandom));
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
